// File: rtl/seven_segment_pkg.sv
// Glyph patterns for the active-low seven-segment bus (bit6=a .. bit0=g),
// shared between the capture block and the display decoder.
package seven_segment_pkg;

    localparam logic [6:0] GLYPH_0   = 7'h01;
    localparam logic [6:0] GLYPH_1   = 7'h4F;
    localparam logic [6:0] GLYPH_2   = 7'h12;
    localparam logic [6:0] GLYPH_3   = 7'h06;
    localparam logic [6:0] GLYPH_4   = 7'h4C;
    localparam logic [6:0] GLYPH_5   = 7'h24;
    localparam logic [6:0] GLYPH_6   = 7'h20;
    localparam logic [6:0] GLYPH_7   = 7'h0F;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h04;
    localparam logic [6:0] GLYPH_A   = 7'h02;
    localparam logic [6:0] GLYPH_B   = 7'h60;
    localparam logic [6:0] GLYPH_C   = 7'h31;
    localparam logic [6:0] GLYPH_D   = 7'h42;
    localparam logic [6:0] GLYPH_E   = 7'h30;
    localparam logic [6:0] GLYPH_F   = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODE_BLANK = 4'hF;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational pattern-to-nibble lookup; anything not in the glyph set,
// including the all-off pattern, decodes to 0 with the illegal flag raised.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       illegal_o
);

    always_comb begin
        nibble_o  = 4'h0;
        illegal_o = 1'b0;
        case (pattern_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures a multiplexed 4-digit seven-segment display into a 16-bit frame,
// accepting each digit once its bus pattern has been stable long enough.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_segments,
    input  logic [3:0]  i_anodes,
    input  logic        i_ready,
    output logic [15:0] o_value,
    output logic [3:0]  o_error,
    output logic        o_valid,
    output logic        o_overrun
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        same, accept, frame_done;
    logic [3:0]  nibble;
    logic        illegal;
    logic [15:0] pend_val_q, pend_val_d;
    logic [3:0]  pend_err_q, pend_err_d;
    logic [3:0]  seen_q, seen_d;
    cap_state_e  state_q;
    logic [15:0] value_q;
    logic [3:0]  error_q;
    logic        overrun_q;

    seven_segment_pattern_decode u_decode (
        .pattern_i (seg_q),
        .nibble_o  (nibble),
        .illegal_o (illegal)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seg_q  <= SEG_BLANK;
            an_q   <= ANODE_BLANK;
            prev_q <= {ANODE_BLANK, SEG_BLANK};
            cnt_q  <= '0;
        end else begin
            seg_q  <= i_segments;
            an_q   <= i_anodes;
            prev_q <= {an_q, seg_q};
            cnt_q  <= cnt_d;
        end
    end

    // Acceptance fires only on the step into CNT_MAX, so a saturated run never re-accepts.
    always_comb begin
        same   = ({an_q, seg_q} == prev_q);
        cnt_d  = cnt_q;
        if (!same)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 8'd1;
        accept = same && (cnt_q == CNT_PRE) && $onehot(~an_q);

        pend_val_d = pend_val_q;
        pend_err_d = pend_err_q;
        seen_d     = seen_q;
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (!an_q[k]) begin
                    pend_val_d[4*k +: 4] = nibble;
                    pend_err_d[k]        = illegal;
                    seen_d[k]            = 1'b1;
                end
            end
        end
        frame_done = accept && (seen_d == 4'hF);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_COLLECT;
            value_q    <= '0;
            error_q    <= '0;
            overrun_q  <= 1'b0;
            pend_val_q <= '0;
            pend_err_q <= '0;
            seen_q     <= '0;
        end else begin
            overrun_q  <= 1'b0;
            pend_val_q <= pend_val_d;
            if (frame_done) begin
                seen_q     <= '0;
                pend_err_q <= '0;
            end else begin
                seen_q     <= seen_d;
                pend_err_q <= pend_err_d;
            end
            case (state_q)
                ST_COLLECT: begin
                    if (frame_done) begin
                        value_q <= pend_val_d;
                        error_q <= pend_err_d;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (frame_done && i_ready) begin
                        value_q <= pend_val_d;
                        error_q <= pend_err_d;
                    end else if (frame_done) begin
                        overrun_q <= 1'b1;
                    end else if (i_ready) begin
                        state_q <= ST_COLLECT;
                    end
                end
            endcase
        end
    end

    assign o_value   = value_q;
    assign o_error   = error_q;
    assign o_valid   = (state_q == ST_HOLD);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with a frame scoreboard popped on
// each accepted handshake.
module tb_seven_segment_capture;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  err;
    logic        valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int ovr_cnt = 0;
    frame_t sb_q[$];

    logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h02, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    always #5 clk = ~clk;

    seven_segment_capture #(.STABLE_CYCLES(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_segments (seg),
        .i_anodes   (an),
        .i_ready    (ready),
        .o_value    (value),
        .o_error    (err),
        .o_valid    (valid),
        .o_overrun  (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (overrun === 1'b1) ovr_cnt++;
            if (valid === 1'b1 && ready === 1'b1) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_frame: observed %0h expected no frame", value);
                end else begin
                    frame_t e;
                    e = sb_q.pop_front();
                    check("frame_value", 32'(value), 32'(e.val));
                    check("frame_error", 32'(err), 32'(e.err));
                end
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input int k, input logic [6:0] s, input int hold);
        logic [3:0] one;
        one = 4'b0001;
        drive(~(one << k), s, hold);
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic send_frame(input logic [15:0] v, input bit rev);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = rev ? 3 - i : i;
            send_digit(k, glyph[v[4*k +: 4]], 6);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        int ovr0;
        rst   = 1'b1;
        seg   = 7'h7F;
        an    = 4'hF;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(value), 32'd0);
        check("reset_error", 32'(err), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        drive(4'hF, 7'h7F, 2);

        // Basic frame 4321
        sb_q.push_back('{val: 16'h4321, err: 4'h0});
        send_digit(0, 7'h4F, 6);
        send_digit(1, 7'h12, 6);
        send_digit(2, 7'h06, 6);
        send_digit(3, 7'h4C, 6);
        wait_drain("basic_drain", 20);
        check("basic_handshakes", 32'(hs_cnt), 32'd1);
        check("basic_valid_low", 32'(valid), 32'd0);

        // Digit 2 held too briefly, then properly
        hs0 = hs_cnt;
        send_digit(0, glyph[8], 6);
        send_digit(1, glyph[7], 6);
        send_digit(2, glyph[6], 3);
        send_digit(3, glyph[5], 6);
        drive(4'hF, 7'h7F, 10);
        check("short_hold_no_frame", 32'(hs_cnt), 32'(hs0));
        check("short_hold_valid_low", 32'(valid), 32'd0);
        sb_q.push_back('{val: 16'h5678, err: 4'h0});
        send_digit(2, glyph[6], 4);
        wait_drain("min_hold_drain", 20);
        check("min_hold_handshakes", 32'(hs_cnt), 32'(hs0 + 1));

        // Illegal all-off pattern on digit 1
        sb_q.push_back('{val: 16'h0000, err: 4'b0010});
        send_digit(0, 7'h01, 6);
        send_digit(1, 7'h7F, 6);
        send_digit(2, 7'h01, 6);
        send_digit(3, 7'h01, 6);
        wait_drain("illegal_drain", 20);

        // Back-pressure: second frame dropped with one overrun pulse
        ready = 1'b0;
        ovr0  = ovr_cnt;
        sb_q.push_back('{val: 16'hBEEF, err: 4'h0});
        send_frame(16'hBEEF, 1'b0);
        check("bp_first_valid", 32'(valid), 32'd1);
        check("bp_first_value", 32'(value), 32'hBEEF);
        send_frame(16'h1234, 1'b0);
        check("bp_held_value", 32'(value), 32'hBEEF);
        check("bp_held_error", 32'(err), 32'd0);
        check("bp_held_valid", 32'(valid), 32'd1);
        check("bp_overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("bp_valid_dropped", 32'(valid), 32'd0);
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Reset mid-frame discards partial digits
        hs0 = hs_cnt;
        send_digit(0, glyph[7], 6);
        send_digit(1, glyph[7], 6);
        send_digit(2, glyph[7], 6);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_value", 32'(value), 32'd0);
        rst = 1'b0;
        drive(4'hF, 7'h7F, 2);
        sb_q.push_back('{val: 16'hCAFE, err: 4'h0});
        send_frame(16'hCAFE, 1'b1);
        wait_drain("midreset_drain", 20);
        check("midreset_handshakes", 32'(hs_cnt), 32'(hs0 + 1));

        // Two anodes low: ignored, pending frame untouched
        hs0 = hs_cnt;
        send_digit(0, glyph[10], 6);
        send_digit(1, glyph[11], 6);
        send_digit(2, glyph[12], 6);
        drive(4'b1100, 7'h20, 20);
        drive(4'hF, 7'h7F, 2);
        check("multi_anode_no_frame", 32'(hs_cnt), 32'(hs0));
        check("multi_anode_valid_low", 32'(valid), 32'd0);
        sb_q.push_back('{val: 16'hDCBA, err: 4'h0});
        send_digit(3, glyph[13], 6);
        wait_drain("multi_anode_drain", 20);
        check("multi_anode_handshakes", 32'(hs_cnt), 32'(hs0 + 1));

        drive(4'hF, 7'h7F, 5);
        check("total_overruns", 32'(ovr_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
